// File: rtl/dca_mru_step_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dca_mru_step_sequencer_pkg
// Shared MRU instruction definitions for the step sequencer.
//   BW_DCA_MRU_OPCODE            : width of an MRU opcode
//   DCA_MRU_OPCODE_INDEX_*       : bit positions of the opcode flags
//   BW_BLOCKED_STEP_INST         : width of a step instruction {last, opcode}
//   pack_step_inst()             : builds a step instruction word
// -----------------------------------------------------------------------------
package dca_mru_step_sequencer_pkg;

    localparam int BW_DCA_MRU_OPCODE                 = 3;
    localparam int DCA_MRU_OPCODE_INDEX_TRANSPOSE    = 0;
    localparam int DCA_MRU_OPCODE_INDEX_FILL         = 1;
    localparam int DCA_MRU_OPCODE_INDEX_LSU0_REQUEST = 2;

    // A step instruction carries the opcode plus a "last step" flag on top.
    localparam int BW_BLOCKED_STEP_INST = BW_DCA_MRU_OPCODE + 1;

    function automatic logic [BW_BLOCKED_STEP_INST-1:0] pack_step_inst(
        input logic                         last,
        input logic [BW_DCA_MRU_OPCODE-1:0] opcode
    );
        return {last, opcode};
    endfunction

endpackage

// File: rtl/dca_mru_step_sequencer.sv
// -----------------------------------------------------------------------------
// dca_mru_step_sequencer
// Accepts one MRU command (opcode + step count), issues that many step
// instructions to the MRU step executor, then waits for the executor to report
// that the last step has drained before pulsing done.
//
// Ports
//   clk, rstnn          : clock, asynchronous active-low reset
//   clear               : synchronous abort back to IDLE (highest priority)
//   cmd_valid/ready     : command handshake
//   cmd_opcode          : MRU opcode (transpose / fill / LSU0-request flags)
//   cmd_num_step        : number of steps to issue (0 allowed)
//   step_valid/ready    : step handshake towards the executor
//   step_inst           : {last, opcode}
//   exec_done           : executor pulse, last step fully drained
//   busy                : high in ISSUE and DRAIN
//   done                : one-cycle completion pulse
//   issued_count        : steps issued for the current command
// -----------------------------------------------------------------------------
module dca_mru_step_sequencer
    import dca_mru_step_sequencer_pkg::*;
#(
    parameter int MATRIX_SIZE_PARA = 8,
    parameter int BW_STEP_COUNT    = 16
)(
    input  logic                            clk,
    input  logic                            rstnn,
    input  logic                            clear,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [BW_DCA_MRU_OPCODE-1:0]    cmd_opcode,
    input  logic [BW_STEP_COUNT-1:0]        cmd_num_step,
    output logic                            step_valid,
    input  logic                            step_ready,
    output logic [BW_BLOCKED_STEP_INST-1:0] step_inst,
    input  logic                            exec_done,
    output logic                            busy,
    output logic                            done,
    output logic [BW_STEP_COUNT-1:0]        issued_count
);

    // The matrix size is only passed through from the DCA configuration; reject
    // nonsensical values at elaboration.
    if (MATRIX_SIZE_PARA <= 0) begin : g_bad_matrix_size
        $error("MATRIX_SIZE_PARA must be positive");
    end

    localparam logic [1:0] ST_ENC_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENC_ISSUE = 2'd1;
    localparam logic [1:0] ST_ENC_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_ENC_IDLE,
        ST_ISSUE = ST_ENC_ISSUE,
        ST_DRAIN = ST_ENC_DRAIN
    } state_t;

    localparam logic [BW_STEP_COUNT-1:0] CNT_ZERO = '0;
    localparam logic [BW_STEP_COUNT-1:0] CNT_ONE  = BW_STEP_COUNT'(1);

    state_t                         r_state;
    logic [BW_STEP_COUNT-1:0]       r_remaining;
    logic [BW_STEP_COUNT-1:0]       r_issued_count;
    logic [BW_DCA_MRU_OPCODE-1:0]   r_opcode;
    logic                           r_done;

    logic                           w_accept;
    logic                           w_last;

    assign cmd_ready    = (r_state == ST_IDLE) && !clear;
    assign w_accept     = cmd_valid && cmd_ready;
    assign step_valid   = (r_state == ST_ISSUE);
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign issued_count = r_issued_count;
    assign w_last       = (r_remaining == CNT_ONE);

    // step_inst is built purely from registers, so it cannot change while the
    // executor is stalling us.
    always_comb begin
        step_inst = pack_step_inst(w_last, {BW_DCA_MRU_OPCODE{1'b0}});
        step_inst[DCA_MRU_OPCODE_INDEX_TRANSPOSE]    = r_opcode[DCA_MRU_OPCODE_INDEX_TRANSPOSE];
        step_inst[DCA_MRU_OPCODE_INDEX_FILL]         = r_opcode[DCA_MRU_OPCODE_INDEX_FILL];
        step_inst[DCA_MRU_OPCODE_INDEX_LSU0_REQUEST] = r_opcode[DCA_MRU_OPCODE_INDEX_LSU0_REQUEST];
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state        <= ST_IDLE;
            r_remaining    <= CNT_ZERO;
            r_issued_count <= CNT_ZERO;
            r_opcode       <= '0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                // Abort wins over every handshake in this cycle; no done pulse.
                r_state        <= ST_IDLE;
                r_remaining    <= CNT_ZERO;
                r_issued_count <= CNT_ZERO;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_opcode       <= cmd_opcode;
                            r_remaining    <= cmd_num_step;
                            r_issued_count <= CNT_ZERO;
                            // An empty command completes immediately from IDLE.
                            if (cmd_num_step == CNT_ZERO) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        // The remaining guard keeps the counter from wrapping.
                        if (step_ready && (r_remaining != CNT_ZERO)) begin
                            r_remaining    <= r_remaining - CNT_ONE;
                            r_issued_count <= r_issued_count + CNT_ONE;
                            if (w_last) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (exec_done) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
